// File: rtl/xbar_cache_refill_rr_pkg.sv
// Shared sizing helpers and tag-field macros for the N-port cache refill crossbar.
// Optional feature macro used by the top: XBAR_REFILL_PERF_EN.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef DC_MEM_TAG_BITS
`define DC_MEM_TAG_BITS 8
`endif

// Memory tag layout is {port_id, port_tag}; these slice it given the port-tag width.
`define XBAR_TAG_ID(tag, ptb) tag[(ptb) +: ID_BITS]
`define XBAR_TAG_PT(tag, ptb) tag[(ptb)-1:0]

package xbar_cache_refill_rr_pkg;

  // A 2-port crossbar still needs one id bit.
  function automatic int xbar_id_bits(input int nports);
    return (nports <= 2) ? 1 : $clog2(nports);
  endfunction

  function automatic int xbar_mem_tag_bits(input int nports, input int port_tag_bits);
    return xbar_id_bits(nports) + port_tag_bits;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Rotating-priority one-hot arbiter; priority pointer moves past the winner on each update.
module xbar_rr_arbiter #(
  parameter int NPORTS  = 3,
  parameter int ID_BITS = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NPORTS-1:0]  i_req,
  input  logic               i_update,
  output logic [NPORTS-1:0]  o_grant,
  output logic [ID_BITS-1:0] o_grant_id,
  output logic               o_any
);

  logic [ID_BITS-1:0] r_ptr;
  logic               w_hi_any;
  logic               w_lo_any;
  logic [ID_BITS-1:0] w_hi_id;
  logic [ID_BITS-1:0] w_lo_id;
  logic               w_hit;

  // Lowest requester at/after the pointer wins, else the lowest requester overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_id  = '0;
    w_lo_id  = '0;
    w_hit    = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      w_hit    = i_req[i] & (ID_BITS'(i) >= r_ptr);
      w_lo_any = w_lo_any | i_req[i];
      w_lo_id  = i_req[i] ? ID_BITS'(i) : w_lo_id;
      w_hi_any = w_hi_any | w_hit;
      w_hi_id  = w_hit ? ID_BITS'(i) : w_hi_id;
    end
  end

  assign o_any      = w_lo_any;
  assign o_grant_id = w_hi_any ? w_hi_id : w_lo_id;

  // One-hot expansion of the winning id.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NPORTS; i++) begin
      o_grant[i] = o_any & (o_grant_id == ID_BITS'(i));
    end
  end

  // Priority pointer advances only on a grant the output stage actually takes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_update && o_any) begin
      r_ptr <= (o_grant_id == ID_BITS'(NPORTS - 1)) ? '0 : o_grant_id + ID_BITS'(1);
    end
  end

endmodule

// File: rtl/xbar_cache_refill_rr.sv
// N-port cache refill/writeback crossbar: round-robin onto one registered mem request, tag-routed responses.
// Define XBAR_REFILL_PERF_EN to add per-port grant/stall performance counters.
module xbar_cache_refill_rr
  import xbar_cache_refill_rr_pkg::*;
#(
  parameter  int NPORTS          = 3,
  parameter  int ADDR_BITS       = `MEM_ADDR_BITS,
  parameter  int PORT_TAG_BITS   = `DC_MEM_TAG_BITS,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int REFILL_BEATS    = 4,
  localparam int ID_BITS         = xbar_id_bits(NPORTS),
  localparam int MEM_TAG_BITS    = xbar_mem_tag_bits(NPORTS, PORT_TAG_BITS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NPORTS-1:0]               i_port_req_val,
  output logic [NPORTS-1:0]               o_port_req_rdy,
  input  logic [NPORTS-1:0]               i_port_req_rw,
  input  logic [NPORTS*ADDR_BITS-1:0]     i_port_req_addr,
  input  logic [NPORTS*PORT_TAG_BITS-1:0] i_port_req_tag,
  output logic [NPORTS-1:0]               o_port_resp_val,
  output logic [NPORTS-1:0]               o_port_resp_nack,
  output logic                            o_mem_req_val,
  input  logic                            i_mem_req_rdy,
  output logic                            o_mem_req_rw,
  output logic [ADDR_BITS-1:0]            o_mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]         o_mem_req_tag,
  input  logic                            i_mem_resp_val,
  input  logic                            i_mem_resp_nack,
  input  logic [MEM_TAG_BITS-1:0]         i_mem_resp_tag
`ifdef XBAR_REFILL_PERF_EN
  ,
  output logic [NPORTS*32-1:0]            o_perf_grant_cnt,
  output logic [NPORTS*32-1:0]            o_perf_stall_cnt
`endif
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W = (REFILL_BEATS > 1) ? $clog2(REFILL_BEATS) : 1;

  logic                     r_mem_req_val;
  logic                     r_mem_req_rw;
  logic [ADDR_BITS-1:0]     r_mem_req_addr;
  logic [MEM_TAG_BITS-1:0]  r_mem_req_tag;

  logic                     w_load;
  logic [NPORTS-1:0]        w_elig;
  logic [NPORTS-1:0]        w_grant;
  logic [ID_BITS-1:0]       w_gid;
  logic                     w_any;
  logic                     w_sel_rw;
  logic [ADDR_BITS-1:0]     w_sel_addr;
  logic [PORT_TAG_BITS-1:0] w_sel_tag;
  logic [ID_BITS-1:0]       w_resp_id;
  logic                     w_resp_ok;
  logic                     w_unused_resp_tag;

  assign w_load = ~r_mem_req_val | i_mem_req_rdy;

  xbar_rr_arbiter #(
    .NPORTS  (NPORTS),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (w_elig),
    .i_update   (w_load),
    .o_grant    (w_grant),
    .o_grant_id (w_gid),
    .o_any      (w_any)
  );

  assign o_port_req_rdy = w_load ? w_grant : '0;

  // Pick the winning port's request fields.
  always_comb begin
    w_sel_rw   = 1'b0;
    w_sel_addr = '0;
    w_sel_tag  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_sel_rw   = w_grant[i] ? i_port_req_rw[i] : w_sel_rw;
      w_sel_addr = w_grant[i] ? i_port_req_addr[i*ADDR_BITS +: ADDR_BITS] : w_sel_addr;
      w_sel_tag  = w_grant[i] ? i_port_req_tag[i*PORT_TAG_BITS +: PORT_TAG_BITS] : w_sel_tag;
    end
  end

  // One-entry output register: refills whenever empty or being drained, else holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req_val  <= 1'b0;
      r_mem_req_rw   <= 1'b0;
      r_mem_req_addr <= '0;
      r_mem_req_tag  <= '0;
    end else if (w_load) begin
      r_mem_req_val <= w_any;
      if (w_any) begin
        r_mem_req_rw   <= w_sel_rw;
        r_mem_req_addr <= w_sel_addr;
        r_mem_req_tag  <= {w_gid, w_sel_tag};
      end
    end
  end

  assign o_mem_req_val  = r_mem_req_val;
  assign o_mem_req_rw   = r_mem_req_rw;
  assign o_mem_req_addr = r_mem_req_addr;
  assign o_mem_req_tag  = r_mem_req_tag;

  assign w_resp_id         = `XBAR_TAG_ID(i_mem_resp_tag, PORT_TAG_BITS);
  assign w_resp_ok         = int'(w_resp_id) < NPORTS;
  assign w_unused_resp_tag = ^`XBAR_TAG_PT(i_mem_resp_tag, PORT_TAG_BITS);

  // Responses carrying an id beyond the port count go nowhere.
  always_comb begin
    o_port_resp_val  = '0;
    o_port_resp_nack = '0;
    for (int i = 0; i < NPORTS; i++) begin
      o_port_resp_val[i]  = i_mem_resp_val  & w_resp_ok & (w_resp_id == ID_BITS'(i));
      o_port_resp_nack[i] = i_mem_resp_nack & w_resp_ok & (w_resp_id == ID_BITS'(i));
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    logic [OUT_W-1:0]  r_outstanding;
    logic [BEAT_W-1:0] r_beat;
    logic              w_inc;
    logic              w_last;
    logic              w_dec;

    assign w_elig[g] = i_port_req_val[g] &
                       (i_port_req_rw[g] | (r_outstanding < OUT_W'(MAX_OUTSTANDING)));
    assign w_inc     = o_port_req_rdy[g] & ~i_port_req_rw[g];
    assign w_last    = o_port_resp_val[g] & (r_beat == BEAT_W'(REFILL_BEATS - 1));
    assign w_dec     = w_last | o_port_resp_nack[g];

    // A same-cycle read grant and completion cancel; a stray completion never underflows.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_outstanding <= '0;
        r_beat        <= '0;
      end else begin
        if (w_inc && !w_dec) begin
          r_outstanding <= r_outstanding + OUT_W'(1);
        end else if (w_dec && !w_inc && (r_outstanding != '0)) begin
          r_outstanding <= r_outstanding - OUT_W'(1);
        end
        if (o_port_resp_nack[g]) begin
          r_beat <= '0;
        end else if (o_port_resp_val[g]) begin
          r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
        end
      end
    end

`ifdef XBAR_REFILL_PERF_EN
    logic [31:0] r_perf_grant;
    logic [31:0] r_perf_stall;

    // Free-running wrap-around counters of grants and of cycles spent waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_perf_grant <= 32'd0;
        r_perf_stall <= 32'd0;
      end else begin
        r_perf_grant <= r_perf_grant + 32'(o_port_req_rdy[g]);
        r_perf_stall <= r_perf_stall + 32'(i_port_req_val[g] & ~o_port_req_rdy[g]);
      end
    end

    assign o_perf_grant_cnt[g*32 +: 32] = r_perf_grant;
    assign o_perf_stall_cnt[g*32 +: 32] = r_perf_stall;
`endif
  end

endmodule
